// File: rtl/mult_div_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
package mult_div_pkg;

    localparam int MD_WIDTH = 32;
    localparam int MD_STEPS = 32;
    localparam int CNT_W    = $clog2(MD_STEPS);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MULT = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } md_state_e;

    // StoreMD codes as emitted by the ALU control decoder.
    typedef enum logic [1:0] {
        STORE_NONE = 2'b00,
        STORE_DIV  = 2'b01,
        STORE_MULT = 2'b10
    } store_md_e;

endpackage

// File: rtl/div_restoring_core.sv
// Signed restoring divider: magnitude datapath plus step counter.
// Results are presented combinationally for the step being taken so the
// caller can latch them on the final edge.
module div_restoring_core
    import mult_div_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    start,
    input  logic                    run,
    input  logic signed [WIDTH-1:0] dividend,
    input  logic signed [WIDTH-1:0] divisor,
    output logic                    last,
    output logic [WIDTH-1:0]        quotient,
    output logic [WIDTH-1:0]        remainder
);

    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(MD_STEPS - 1);

    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? (~v + 1'b1) : v;
    endfunction

    function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic neg);
        return neg ? (~v + 1'b1) : v;
    endfunction

    logic [WIDTH-1:0] rem_q, rem_d, quo_q, quo_d, dmag_q, dmag_d;
    logic             q_neg_q, q_neg_d, r_neg_q, r_neg_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] sub_w, rem_nx, quo_nx;
    logic             ge;

    // One restoring step: shift in the next dividend bit, subtract if it fits.
    // The partial remainder stays below the divisor, so W bits hold it.
    assign shifted = {rem_q, quo_q[WIDTH-1]};
    assign ge      = shifted >= {1'b0, dmag_q};
    assign sub_w   = shifted[WIDTH-1:0] - dmag_q;
    assign rem_nx  = ge ? sub_w : shifted[WIDTH-1:0];
    assign quo_nx  = {quo_q[WIDTH-2:0], ge};

    assign last      = run && (cnt_q == LAST_STEP);
    assign quotient  = cond_neg(quo_nx, q_neg_q);
    assign remainder = cond_neg(rem_nx, r_neg_q);

    always_comb begin
        rem_d   = rem_q;
        quo_d   = quo_q;
        dmag_d  = dmag_q;
        q_neg_d = q_neg_q;
        r_neg_d = r_neg_q;
        cnt_d   = cnt_q;
        if (start) begin
            rem_d   = '0;
            quo_d   = magnitude(dividend);
            dmag_d  = magnitude(divisor);
            q_neg_d = dividend[WIDTH-1] ^ divisor[WIDTH-1];
            r_neg_d = dividend[WIDTH-1];
            cnt_d   = '0;
        end else if (run) begin
            rem_d = rem_nx;
            quo_d = quo_nx;
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        rem_q   <= rem_d;
        quo_q   <= quo_d;
        dmag_q  <= dmag_d;
        q_neg_q <= q_neg_d;
        r_neg_q <= r_neg_d;
    end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative signed multiply (radix-2 Booth) / divide (restoring) unit with a
// busy/done handshake; requests are rising-edge detected on multOp/divOp.
module mult_div_unit
    import mult_div_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    multOp,
    input  logic                    divOp,
    input  logic signed [WIDTH-1:0] opA,
    input  logic signed [WIDTH-1:0] opB,
    output logic [WIDTH-1:0]        hi,
    output logic [WIDTH-1:0]        lo,
    output logic                    busy,
    output logic                    done,
    output logic                    divZero
);

    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(MD_STEPS - 1);

    // Accumulator layout {A, Q, q-1}. The add/sub is done one bit wider so a
    // most-negative multiplicand cannot overflow A before the shift.
    function automatic logic [2*WIDTH:0] booth_step(input logic [2*WIDTH:0] acc,
                                                    input logic signed [WIDTH-1:0] m);
        logic signed [WIDTH:0] a_ext, m_ext, sum;
        a_ext = {acc[2*WIDTH], acc[2*WIDTH:WIDTH+1]};
        m_ext = {m[WIDTH-1], m};
        case (acc[1:0])
            2'b01:   sum = a_ext + m_ext;
            2'b10:   sum = a_ext - m_ext;
            default: sum = a_ext;
        endcase
        return {sum, acc[WIDTH:1]};
    endfunction

    md_state_e               state_q, state_d;
    logic                    mult_q, div_q;
    logic                    busy_q, busy_d, done_q, done_d, dz_q, dz_d;
    logic [WIDTH-1:0]        hi_q, hi_d, lo_q, lo_d;
    logic [CNT_W-1:0]        mcnt_q, mcnt_d;
    logic [2*WIDTH:0]        acc_q, acc_d, booth_nx;
    logic signed [WIDTH-1:0] mcand_q, mcand_d;
    logic                    mult_rise, div_rise, div_start, div_run, div_last;
    logic [WIDTH-1:0]        div_quo, div_rem;

    assign mult_rise = multOp & ~mult_q;
    assign div_rise  = divOp & ~div_q;
    assign booth_nx  = booth_step(acc_q, mcand_q);
    assign div_run   = (state_q == ST_DIV);

    div_restoring_core #(.WIDTH(WIDTH)) u_div (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (div_start),
        .run       (div_run),
        .dividend  (opA),
        .divisor   (opB),
        .last      (div_last),
        .quotient  (div_quo),
        .remainder (div_rem)
    );

    always_comb begin
        state_d   = state_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        dz_d      = 1'b0;
        hi_d      = hi_q;
        lo_d      = lo_q;
        mcnt_d    = mcnt_q;
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        div_start = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // Divide wins a simultaneous request; the multiply is dropped.
                if (div_rise) begin
                    busy_d = 1'b1;
                    if (opB == '0) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                        dz_d    = 1'b1;
                    end else begin
                        state_d   = ST_DIV;
                        div_start = 1'b1;
                    end
                end else if (mult_rise) begin
                    busy_d  = 1'b1;
                    state_d = ST_MULT;
                    acc_d   = {{WIDTH{1'b0}}, opB, 1'b0};
                    mcand_d = opA;
                    mcnt_d  = '0;
                end
            end
            ST_MULT: begin
                acc_d  = booth_nx;
                mcnt_d = mcnt_q + 1'b1;
                if (mcnt_q == LAST_STEP) begin
                    hi_d    = booth_nx[2*WIDTH:WIDTH+1];
                    lo_d    = booth_nx[WIDTH:1];
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end
            end
            ST_DIV: begin
                if (div_last) begin
                    hi_d    = div_rem;
                    lo_d    = div_quo;
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            mult_q  <= 1'b0;
            div_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dz_q    <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            mcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            mult_q  <= multOp;
            div_q   <= divOp;
            busy_q  <= busy_d;
            done_q  <= done_d;
            dz_q    <= dz_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            mcnt_q  <= mcnt_d;
        end
    end

    always_ff @(posedge clk) begin
        acc_q   <= acc_d;
        mcand_q <= mcand_d;
    end

    assign hi      = hi_q;
    assign lo      = lo_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign divZero = dz_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Randomized self-checking bench for mult_div_unit against a 64-bit arithmetic model.
module tb_mult_div_unit;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        multOp = 1'b0;
    logic        divOp = 1'b0;
    logic [31:0] opA = '0;
    logic [31:0] opB = '0;
    logic [31:0] hi, lo;
    logic        busy, done, divZero;

    int n_checks = 0;
    int n_fail = 0;
    logic [31:0] exp_hi = '0;
    logic [31:0] exp_lo = '0;

    mult_div_unit #(.WIDTH(32)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .multOp  (multOp),
        .divOp   (divOp),
        .opA     (opA),
        .opB     (opB),
        .hi      (hi),
        .lo      (lo),
        .busy    (busy),
        .done    (done),
        .divZero (divZero)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: exact signed product, or truncating divide computed in 64 bits.
    task automatic model(input bit is_div, input logic [31:0] a, input logic [31:0] b,
                         output bit dz);
        longint p, q, r;
        dz = 1'b0;
        if (is_div) begin
            if (b == 32'd0) begin
                dz = 1'b1;
            end else begin
                q = longint'($signed(a)) / longint'($signed(b));
                r = longint'($signed(a)) % longint'($signed(b));
                exp_lo = q[31:0];
                exp_hi = r[31:0];
            end
        end else begin
            p = longint'($signed(a)) * longint'($signed(b));
            exp_hi = p[63:32];
            exp_lo = p[31:0];
        end
    endtask

    // mode: 0 = multiply, 1 = divide, 2 = both rise together (divide expected)
    task automatic do_op(input int mode, input logic [31:0] a, input logic [31:0] b);
        int  cycles;
        bit  dz;
        model(mode != 0, a, b, dz);
        @(negedge clk);
        opA = a;
        opB = b;
        multOp = (mode != 1);
        divOp = (mode != 0);
        @(posedge clk);
        #1;
        check_val("busy_after_start", busy, 1);
        multOp = 1'b0;
        divOp = 1'b0;
        opA = $urandom;
        opB = $urandom;
        cycles = 0;
        while (!done && cycles < 40) begin
            @(posedge clk);
            #1;
            cycles++;
        end
        check_val($sformatf("latency m%0d a=%0h b=%0h", mode, a, b), cycles, dz ? 0 : 32);
        check_val($sformatf("hi m%0d a=%0h b=%0h", mode, a, b), hi, exp_hi);
        check_val($sformatf("lo m%0d a=%0h b=%0h", mode, a, b), lo, exp_lo);
        check_val("divZero", divZero, dz);
        @(posedge clk);
        #1;
        check_val("done_one_cycle", done, 0);
        check_val("busy_fall", busy, 0);
    endtask

    logic [31:0] corners [6] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0001,
                                 32'h7FFF_FFFF, 32'h0000_0000, 32'hFFFF_FFFE};

    initial begin
        int n_done;
        logic [31:0] a, b;
        int mode;

        repeat (3) @(posedge clk);
        #1;
        check_val("rst_hi", hi, 0);
        check_val("rst_lo", lo, 0);
        check_val("rst_busy", busy, 0);
        check_val("rst_done", done, 0);
        check_val("rst_divzero", divZero, 0);
        @(negedge clk);
        reset_n = 1'b1;

        do_op(0, 32'd7, -32'sd3);
        do_op(0, 32'h8000_0000, 32'h8000_0000);
        do_op(1, -32'sd7, 32'd2);
        do_op(1, 32'd5, 32'd0);
        do_op(1, 32'h8000_0000, 32'hFFFF_FFFF);
        do_op(2, 32'd100, 32'd7);

        // Held request: exactly one operation, operand change while busy ignored.
        @(negedge clk);
        opA = 32'd3;
        opB = 32'd4;
        multOp = 1'b1;
        n_done = 0;
        for (int i = 0; i < 80; i++) begin
            @(posedge clk);
            #1;
            if (i == 3) opA = 32'd1000;
            if (done) begin
                n_done++;
                check_val("held_lo", lo, 12);
                check_val("held_hi", hi, 0);
            end
        end
        check_val("held_done_count", n_done, 1);
        multOp = 1'b0;
        exp_hi = 32'd0;
        exp_lo = 32'd12;

        // Asynchronous reset in the middle of a divide.
        @(negedge clk);
        opA = -32'sd100;
        opB = 32'd3;
        divOp = 1'b1;
        @(posedge clk);
        #1;
        divOp = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check_val("arst_busy", busy, 0);
        check_val("arst_done", done, 0);
        check_val("arst_hi", hi, 0);
        check_val("arst_lo", lo, 0);
        exp_hi = '0;
        exp_lo = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        do_op(1, 32'd1000, -32'sd7);

        for (int k = 0; k < 24; k++) begin
            mode = $urandom_range(0, 2);
            a = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)] : $urandom;
            b = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)] : $urandom;
            if ($urandom_range(0, 2) == 0) b = b >> $urandom_range(0, 31);
            do_op(mode, a, b);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
